// File: rtl/adder_cpe_pkg.sv
// Shared definitions for the CPE-protected adder pipeline: operation encodings
// and the default check-code generator polynomial.
package adder_cpe_pkg;

   // 2'b11 is reserved and executes as an add
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDC = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   // x^8 + x^2 + x + 1, leading term implicit
   localparam logic [7:0] DEF_POLY = 8'h07;

endpackage

// File: rtl/cpe_crc_enc.sv
// Combinational CRC check-bit encoder: chk = (data * x^NCHK) mod (x^NCHK + POLY).
// Bit-serial LFSR, MSB first, zero seed, fully unrolled over the data width.
module cpe_crc_enc
   import adder_cpe_pkg::*;
#(
   parameter int unsigned     NBIT = 7,
   parameter int unsigned     NCHK = 8,
   parameter logic [NCHK-1:0] POLY = DEF_POLY
) (
   input  logic [NBIT-1:0] data,
   output logic [NCHK-1:0] chk
);

   // crc[i] is the LFSR state after consuming i data bits
   logic [NBIT:0][NCHK-1:0] crc;

   assign crc[0] = '0;

   for (genvar i = 0; i < NBIT; i++) begin : g_step
      logic fb;
      assign fb         = crc[i][NCHK-1] ^ data[NBIT-1-i];
      assign crc[i+1]   = {crc[i][NCHK-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   assign chk = crc[NBIT];

endmodule

// File: rtl/adder_cpe_pipe.sv
// Two-stage valid/ready adder/subtractor. Stage 1 holds the arithmetic result,
// stage 2 holds the sum with its CRC check bits. Also counts retired results that
// carried (or borrowed) out, saturating.
module adder_cpe_pipe
   import adder_cpe_pkg::*;
#(
   parameter int unsigned               NBIT  = 7,
   parameter int unsigned               NCODE = 15,
   parameter logic [NCODE-NBIT-1:0]     POLY  = DEF_POLY,
   parameter int unsigned               NCNT  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBIT-1:0]  a,
   input  logic [NBIT-1:0]  b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NCODE-1:0] code,
   output logic             cout,
   output logic [NCNT-1:0]  cnt,
   input  logic             cnt_clr
);

   localparam int unsigned NCHK = NCODE - NBIT;

   logic            s1_en, s2_en;
   logic            s1_valid_q, s2_valid_q;
   logic [NBIT-1:0] s1_sum_q;
   logic            s1_cout_q;
   logic [NBIT:0]   res;
   logic            res_cout;
   logic [NCHK-1:0] chk;
   logic [NCODE-1:0] code_q;
   logic            cout_q;
   logic [NCNT-1:0] cnt_q, cnt_d;

   // A stage may load when it is empty or its contents leave this cycle
   assign s2_en    = !s2_valid_q || out_ready;
   assign s1_en    = !s1_valid_q || s2_en;
   assign in_ready = s1_en;

   // Operand arithmetic; SUB reports borrow as the inverted carry
   always_comb begin
      res      = '0;
      res_cout = 1'b0;
      case (op_e'(op))
         OP_SUB:  res = {1'b0, a} + {1'b0, ~b} + {{NBIT{1'b0}}, 1'b1};
         OP_ADDC: res = {1'b0, a} + {1'b0, b} + {{NBIT{1'b0}}, cin};
         default: res = {1'b0, a} + {1'b0, b};
      endcase
      res_cout = (op_e'(op) == OP_SUB) ? ~res[NBIT] : res[NBIT];
   end

   // Stage 1: capture result on accepted input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_cout_q  <= 1'b0;
      end else if (s1_en) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sum_q  <= res[NBIT-1:0];
            s1_cout_q <= res_cout;
         end
      end
   end

   cpe_crc_enc #(
      .NBIT (NBIT),
      .NCHK (NCHK),
      .POLY (POLY)
   ) u_crc (
      .data (s1_sum_q),
      .chk  (chk)
   );

   // Stage 2: capture codeword; holds while stalled downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         code_q     <= '0;
         cout_q     <= 1'b0;
      end else if (s2_en) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            code_q <= {s1_sum_q, chk};
            cout_q <= s1_cout_q;
         end
      end
   end

   // Carry-event counter next state; clear beats increment
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (s2_valid_q && out_ready && cout_q && (cnt_q != {NCNT{1'b1}})) begin
         cnt_d = cnt_q + NCNT'(1);
      end
   end

   // Carry-event counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign code      = code_q;
   assign cout      = cout_q;
   assign cnt       = cnt_q;

endmodule

// File: tb/tb_adder_cpe_pipe.sv
// Self-checking bench for adder_cpe_pipe: directed cases plus a queue-based
// scoreboard fed on every accepted input and drained on every retired output.
module tb_adder_cpe_pipe;
   import adder_cpe_pkg::*;

   localparam int unsigned TB_NCNT = 2;
   localparam int unsigned CNT_MAX = (1 << TB_NCNT) - 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  a, b;
   logic [1:0]  op;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] code;
   logic        cout;
   logic [TB_NCNT-1:0] cnt;
   logic        cnt_clr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] sb[$];
   int          cnt_m;
   logic        prev_stall;
   logic [15:0] prev_word;
   logic [15:0] exp_word;
   logic        xfer;
   int          lat;

   adder_cpe_pipe #(
      .NBIT  (7),
      .NCODE (15),
      .POLY  (8'h07),
      .NCNT  (TB_NCNT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .code      (code),
      .cout      (cout),
      .cnt       (cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {cout, sum, chk} with chk from polynomial long division
   function automatic logic [15:0] model(input logic [1:0] o, input logic [6:0] x,
                                         input logic [6:0] y, input logic c);
      logic [7:0]  r;
      logic        co;
      logic [14:0] rem;
      case (o)
         2'b01: begin
            r  = {1'b0, x} + {1'b0, ~y} + 8'd1;
            co = ~r[7];
         end
         2'b10: begin
            r  = {1'b0, x} + {1'b0, y} + {7'd0, c};
            co = r[7];
         end
         default: begin
            r  = {1'b0, x} + {1'b0, y};
            co = r[7];
         end
      endcase
      rem = {r[6:0], 8'h00};
      for (int i = 14; i >= 8; i--) begin
         if (rem[i]) rem[i-:9] = rem[i-:9] ^ 9'h107;
      end
      return {co, r[6:0], rem[7:0]};
   endfunction

   // Monitor: sample handshakes mid-cycle, inputs only change just after posedge
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         cnt_m      = 0;
         prev_stall = 1'b0;
      end else begin
         check("cnt", 32'(cnt), 32'(cnt_m));
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_word", 32'({cout, code}), 32'(prev_word));
         end
         if (in_valid && in_ready) sb.push_back(model(op, a, b, cin));
         xfer = out_valid && out_ready;
         if (xfer) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd0, 32'd1);
            end else begin
               exp_word = sb.pop_front();
               check("sb_word", 32'({cout, code}), 32'(exp_word));
            end
         end
         if (cnt_clr) cnt_m = 0;
         else if (xfer && cout && cnt_m != CNT_MAX) cnt_m++;
         prev_stall = out_valid && !out_ready;
         prev_word  = {cout, code};
      end
   end

   // Called just after a posedge; returns just after the posedge following acceptance
   task automatic drive(input logic [1:0] o, input logic [6:0] x, input logic [6:0] y,
                        input logic c);
      int k = 0;
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      cin = c;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait for a single result, check it, check it lasts one cycle
   task automatic expect_out(input string tag, input logic [14:0] ec, input logic ecout,
                             output int l);
      l = 0;
      @(negedge clk);
      while (!out_valid && l < 20) begin
         @(negedge clk);
         l++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_code"}, 32'(code), 32'(ec));
      check({tag, "_cout"}, 32'(cout), 32'(ecout));
      @(negedge clk);
      check({tag, "_pulse"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k = 0;
      @(negedge clk);
      while ((sb.size() != 0 || out_valid) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = 2'b00;
      cin       = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_code", 32'(code), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_cnt", 32'(cnt), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic add, latency
      drive(OP_ADD, 7'd0, 7'd1, 1'b0);
      expect_out("t1", 15'h0107, 1'b0, lat);
      check("t1_latency", 32'(lat), 32'd1);

      // Carry out and counter
      drive(OP_ADD, 7'h7F, 7'h03, 1'b0);
      expect_out("t2", 15'h020E, 1'b1, lat);
      check("t2_cnt", 32'(cnt), 32'd1);

      // Subtract: zero result, then borrow
      drive(OP_SUB, 7'd5, 7'd5, 1'b0);
      expect_out("t3a", 15'h0000, 1'b0, lat);
      drive(OP_SUB, 7'd0, 7'd1, 1'b0);
      exp_word = model(2'b01, 7'd0, 7'd1, 1'b0);
      expect_out("t3b", exp_word[14:0], 1'b1, lat);
      check("t3b_sum", 32'(code[14:8]), 32'h7F);

      // Carry-in honoured only by ADDC; reserved op adds
      drive(OP_ADDC, 7'd0, 7'd0, 1'b1);
      expect_out("t4a", 15'h0107, 1'b0, lat);
      drive(OP_ADD, 7'd0, 7'd0, 1'b1);
      expect_out("t4b", 15'h0000, 1'b0, lat);
      drive(OP_RSVD, 7'd0, 7'd1, 1'b1);
      expect_out("t4c", 15'h0107, 1'b0, lat);

      // Back-to-back stream with a 3-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               drive(2'($urandom_range(3, 0)), 7'($urandom), 7'($urandom), 1'($urandom));
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            check("t5_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Saturation
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("t6_clr", 32'(cnt), 32'd0);
      for (int i = 0; i < 5; i++) drive(OP_ADD, 7'h7F, 7'h01, 1'b0);
      drain();
      check("t6_sat", 32'(cnt), 32'd3);

      // Async reset with two results in flight
      drive(OP_ADD, 7'h7F, 7'h7F, 1'b0);
      drive(OP_ADD, 7'h10, 7'h20, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_cnt", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("t6_rel_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("t6_rel_valid", 32'(out_valid), 32'd0);
      drive(OP_ADD, 7'h40, 7'h40, 1'b0);
      drain();
      check("t6_cnt1", 32'(cnt), 32'd1);

      // Clear coinciding with a carry retirement
      drive(OP_ADD, 7'h7F, 7'h02, 1'b0);
      @(posedge clk);
      #1;
      check("t6_clr_valid", 32'(out_valid), 32'd1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("t6_clr_win", 32'(cnt), 32'd0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      check("watchdog", 32'd0, 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
